// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory behind valid/ready request and
// response handshakes, serving the M stage of the pipeline.
//
// Parameters:
//   ADDR_BASE   byte address of array word 0
//   DEPTH_WORDS array depth in 32-bit words (power of two)
//   LATENCY     edges from request accept to resp_valid (1..15)
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_addr/req_wdata    byte address, store data (low bytes for byte/half)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            sign-extend sub-word loads
//   resp_valid/resp_ready response handshake
//   resp_rdata            load data (0 for stores and errors)
//   resp_err              request rejected, no array side effect
//
// Build option: define DMEM_RESP_ERR_EN to flag misaligned, illegal-size and
// out-of-range requests. Without it resp_err is 0, alignment bits below the
// access size are ignored, size 11 acts as word and the index wraps.

module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0100_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_n;

  logic [3:0]  cnt;
  logic        accept;
  logic        commit;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             is_byte;
  logic             is_half;
  logic [3:0]       be;
  logic [31:0]      wrep;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic             acc_err;

  // ---------------- control FSM ----------------

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Reset masks both handshakes immediately and vetoes the
  // commit, so a reset on the commit edge never writes.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        accept    = req_valid && !reset;
        if (accept) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit  = !reset;
          state_n = RESP;
        end
      end
      RESP: begin
        resp_valid = !reset;
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------- request capture / response ----------------

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= CNT_INIT;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_err <= acc_err;
        if (write_q || acc_err) begin
          resp_rdata <= 32'd0;
        end else begin
          resp_rdata <= load_data;
        end
      end
    end
  end

  // ---------------- address decode ----------------

  assign offset  = addr_q - ADDR_BASE;
  assign idx     = offset[IDX_W+1:2];
  assign lane    = addr_q[1:0];
  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);

`ifdef DMEM_RESP_ERR_EN
  logic in_range;
  logic unused_lo;

  assign unused_lo = ^offset[1:0];
  assign in_range  = (addr_q >= ADDR_BASE) &&
                     ((offset >> (IDX_W + 2)) == 32'd0);
  assign acc_err   = (size_q == 2'b11) ||
                     (is_half && addr_q[0]) ||
                     (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                     !in_range;
`else
  logic unused_bits;

  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0]};
  assign acc_err     = 1'b0;
`endif

  // ---------------- lane steering ----------------

  // Store data is replicated across lanes so the byte enables
  // alone pick the destination bytes.
  always_comb begin
    be   = 4'b1111;
    wrep = wdata_q;
    unique case (1'b1)
      is_byte: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata_q[7:0]}};
      end
      is_half: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata_q;
      end
    endcase
  end

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    unique case (1'b1)
      is_byte: begin
        load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
      end
      is_half: begin
        load_data = {{16{signed_q & rd_half[15]}}, rd_half};
      end
      default: begin
        load_data = rd_word;
      end
    endcase
  end

  // ---------------- array ----------------

  // No reset: contents survive reset by design.
  always_ff @(posedge clock) begin
    if (commit && write_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wrep[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven bench with an expected-response queue,
// plus hand sequences for reset, backpressure and reset-at-commit.

module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .ADDR_BASE   (32'h0100_0000),
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sg;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  // Drives one request, waits for accept, pushes the expected
  // response, then waits for resp_valid and checks latency/data.
  task automatic xact(input vec_t v, input string nm);
    int   t0;
    int   n;
    exp_t e;
    @(negedge clock);
    drive(v);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_accept"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    t0 = cyc;
    req_valid = 1'b0;
    sb.push_back('{v.rdata, v.err});
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 50);
    chk({nm, "_lat"}, 32'(cyc - t0), 32'(LAT));
    e = sb.pop_front();
    chk({nm, "_rdata"}, resp_rdata, e.rdata);
    chk({nm, "_err"}, 32'(resp_err), 32'(e.err));
  endtask

  vec_t tbl[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int   t0;
    int   n;

    tbl = '{
      '{1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
      '{1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 2'b00, 1'b0, 32'h0100_0011, 32'hFFFF_FF80, 32'h0000_0000, 1'b0},
      '{1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0000_0000, 32'hDEAD_80EF, 1'b0},
      '{1'b0, 2'b00, 1'b1, 32'h0100_0011, 32'h0000_0000, 32'hFFFF_FF80, 1'b0},
      '{1'b0, 2'b00, 1'b0, 32'h0100_0011, 32'h0000_0000, 32'h0000_0080, 1'b0},
      '{1'b0, 2'b01, 1'b1, 32'h0100_0012, 32'h0000_0000, 32'hFFFF_DEAD, 1'b0},
      '{1'b0, 2'b01, 1'b0, 32'h0100_0010, 32'h0000_0000, 32'h0000_80EF, 1'b0},
      '{1'b0, 2'b00, 1'b1, 32'h0100_0013, 32'h0000_0000, 32'hFFFF_FFDE, 1'b0},
      '{1'b1, 2'b01, 1'b0, 32'h0100_0012, 32'hAAAA_1234, 32'h0000_0000, 1'b0},
      '{1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0000_0000, 32'h1234_80EF, 1'b0},
      '{1'b1, 2'b10, 1'b0, 32'h0100_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0},
      '{1'b0, 2'b01, 1'b1, 32'h0100_0FFE, 32'h0000_0000, 32'hFFFF_CAFE, 1'b0},
      '{1'b1, 2'b10, 1'b0, 32'h0100_0020, 32'h55AA_55AA, 32'h0000_0000, 1'b0},
      '{1'b1, 2'b10, 1'b0, 32'h0100_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0},
      '{1'b0, 2'b10, 1'b1, 32'h0100_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b0}
    };

    // Reset and idle.
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'd0);

    // Main table.
    for (int i = 0; i < 16; i++) begin
      xact(tbl[i], $sformatf("v%0d", i));
    end

    // Backpressure: response held while resp_ready is low.
    @(negedge clock);
    resp_ready = 1'b0;
    v = '{1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, 32'h1234_80EF, 1'b0};
    drive(v);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("bp_accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    t0 = cyc;
    req_valid = 1'b0;
    sb.push_back('{v.rdata, v.err});
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 50);
    chk("bp_lat", 32'(cyc - t0), 32'(LAT));
    e = sb.pop_front();
    // A stray store is offered while the response is stalled.
    v = '{1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'h0000_0BAD, 32'h0, 1'b0};
    drive(v);
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_rdata", resp_rdata, e.rdata);
      chk("bp_hold_err", 32'(resp_err), 32'(e.err));
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clock);
    #1;
    chk("bp_done_valid", 32'(resp_valid), 32'd0);
    chk("bp_done_ready", 32'(req_ready), 32'd1);
    chk("bp_keep_rdata", resp_rdata, e.rdata);
    v = '{1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, 32'h1234_80EF, 1'b0};
    xact(v, "bp_no_stray_write");

    // Reset on the commit edge of a store.
    @(negedge clock);
    v = '{1'b1, 2'b10, 1'b0, 32'h0100_0020, 32'h1111_1111, 32'h0, 1'b0};
    drive(v);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rc_accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rc_resp_valid", 32'(resp_valid), 32'd0);
    chk("rc_req_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rc_idle_ready", 32'(req_ready), 32'd1);
    chk("rc_idle_valid", 32'(resp_valid), 32'd0);
    v = '{1'b0, 2'b10, 1'b0, 32'h0100_0020, 32'h0, 32'h55AA_55AA, 1'b0};
    xact(v, "rc_old_value");

`ifdef DMEM_RESP_ERR_EN
    v = '{1'b1, 2'b10, 1'b0, 32'h0100_0002, 32'h1234_5678, 32'h0, 1'b1};
    xact(v, "err_misaligned_word");
    v = '{1'b0, 2'b10, 1'b0, 32'h0100_0000, 32'h0, 32'h0BAD_F00D, 1'b0};
    xact(v, "err_no_write");
    v = '{1'b0, 2'b11, 1'b0, 32'h0100_0000, 32'h0, 32'h0, 1'b1};
    xact(v, "err_size11");
    v = '{1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0, 32'h0, 1'b1};
    xact(v, "err_below_base");
    v = '{1'b0, 2'b01, 1'b0, 32'h0100_0011, 32'h0, 32'h0, 1'b1};
    xact(v, "err_misaligned_half");
`endif

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
